// File: rtl/pipe_skid_reg.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_skid_reg
//  Description : Registered pipeline stage with valid/ready handshakes on both
//                sides. Holds one main entry plus a one-entry skid buffer so
//                that in_ready can be a flop output while still sustaining one
//                word per cycle. flush squashes all stored entries.
//  Revision    : 1.0  initial release
// ============================================================================
module pipe_skid_reg #(
    parameter int                 WIDTH    = 32,
    parameter logic [WIDTH-1:0]   RST_DATA = '0
) (
    input  logic             clk,
    input  logic             rst,        // synchronous, active-low
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic             r_in_ready;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_data;
    logic [WIDTH-1:0] r_skid;

    logic             w_accept;
    logic             w_take;
    logic             w_load_main_in;
    logic             w_load_main_skid;
    logic             w_load_skid;

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_data;

    assign w_accept = in_valid & r_in_ready;
    assign w_take   = r_out_valid & out_ready;

    // Next-state and payload-steering decode from the current occupancy.
    always_comb begin
        w_state_next     = r_state;
        w_load_main_in   = 1'b0;
        w_load_main_skid = 1'b0;
        w_load_skid      = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                if (w_accept) begin
                    w_state_next   = ST_ONE;
                    w_load_main_in = 1'b1;
                end
            end
            ST_ONE: begin
                if (w_accept && w_take) begin
                    w_load_main_in = 1'b1;
                end else if (w_accept) begin
                    w_state_next = ST_FULL;
                    w_load_skid  = 1'b1;
                end else if (w_take) begin
                    w_state_next = ST_EMPTY;
                end
            end
            ST_FULL: begin
                // in_ready is low here, so only the downstream side can move.
                if (w_take) begin
                    w_state_next     = ST_ONE;
                    w_load_main_skid = 1'b1;
                end
            end
            default: begin
                w_state_next = ST_EMPTY;
            end
        endcase
    end

    // State and handshake flops; reset beats flush, flush beats transfers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= ST_EMPTY;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else if (flush) begin
            r_state     <= ST_EMPTY;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_in_ready  <= (w_state_next != ST_FULL);
            r_out_valid <= (w_state_next != ST_EMPTY);
        end
    end

    // Payload registers; contents are left alone on flush since they are
    // don't-care once the stage is empty.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_data <= RST_DATA;
            r_skid <= RST_DATA;
        end else if (!flush) begin
            if (w_load_main_in) begin
                r_data <= in_data;
            end else if (w_load_main_skid) begin
                r_data <= r_skid;
            end
            if (w_load_skid) begin
                r_skid <= in_data;
            end
        end
    end

endmodule
`default_nettype wire
